alu_ctrl_decode: RTL and testbench

Registered decode stage that turns a fetched RV32I instruction word into the `aluctrl_i` code and operand/immediate controls consumed by the ALU. It drives the control side of the ALU interface and sits between fetch and execute. It has a valid/ready handshake on both sides, a single output register, and a flush input for branch/jump redirect.

---
 rtl/alu_ctrl_decode.sv | 259 +++++++++++++++++++++++++
 tb/tb_alu_ctrl_decode.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_decode.sv
// RV32I decode stage: turns an instruction word into ALU control, immediate and
// register/control flags behind a single valid/ready output register.
module alu_ctrl_decode #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [4:0]      aluctrl_o,
  output logic            alusrc_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            regwrite_o,
  output logic            memread_o,
  output logic            memwrite_o,
  output logic            branch_o,
  output logic            jump_o,
  output logic            illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [4:0] ALU_ADDR  = 5'b01010;
  localparam logic [4:0] ALU_JAL   = 5'b11000;
  localparam logic [4:0] ALU_JALR  = 5'b11001;
  localparam logic [4:0] ALU_LUI   = 5'b11010;
  localparam logic [4:0] ALU_AUIPC = 5'b11011;
  localparam logic [4:0] ALU_ILL   = 5'b11111;

  function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? 5'b00000 : 5'b00001;
      3'b001:  alu_op = 5'b00010;
      3'b010:  alu_op = 5'b00011;
      3'b011:  alu_op = 5'b00100;
      3'b100:  alu_op = 5'b00101;
      3'b101:  alu_op = alt ? 5'b00110 : 5'b00111;
      3'b110:  alu_op = 5'b01000;
      default: alu_op = 5'b01001;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] w);
    imm_i = {{(XLEN-12){w[31]}}, w[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_s(input logic [31:0] w);
    imm_s = {{(XLEN-12){w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [XLEN-1:0] imm_b(input logic [31:0] w);
    imm_b = {{(XLEN-13){w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_u(input logic [31:0] w);
    imm_u = {{(XLEN-32){w[31]}}, w[31:12], 12'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_j(input logic [31:0] w);
    imm_j = {{(XLEN-21){w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_idx;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd_idx = instr_i[11:7];

  logic [4:0]      dec_alu;
  logic            dec_src;
  logic [XLEN-1:0] dec_imm;
  logic            dec_rw, dec_mr, dec_mw, dec_br, dec_jp, dec_ill, wr_rd;

  always_comb begin
    dec_alu = ALU_ILL;
    dec_src = 1'b0;
    dec_imm = '0;
    dec_rw  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_br  = 1'b0;
    dec_jp  = 1'b0;
    dec_ill = 1'b0;
    wr_rd   = 1'b0;
    case (opcode)
      OPC_OP: begin
        wr_rd = 1'b1;
        if (funct7 == 7'b0 || (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
          dec_alu = alu_op(funct3, funct7[5]);
        else
          dec_ill = 1'b1;
      end
      OPC_OPIMM: begin
        wr_rd   = 1'b1;
        dec_src = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shift amount is a zero-extended shamt; imm[11:5] only selects srai.
          dec_imm = {{(XLEN-5){1'b0}}, instr_i[24:20]};
          if (funct7 == 7'b0 || (funct7 == F7_ALT && funct3 == 3'b101))
            dec_alu = alu_op(funct3, funct7[5]);
          else
            dec_ill = 1'b1;
        end else begin
          dec_imm = imm_i(instr_i);
          dec_alu = alu_op(funct3, 1'b0);
        end
      end
      OPC_LOAD: begin
        wr_rd   = 1'b1;
        dec_mr  = 1'b1;
        dec_src = 1'b1;
        dec_imm = imm_i(instr_i);
        dec_alu = ALU_ADDR;
      end
      OPC_STORE: begin
        dec_mw  = 1'b1;
        dec_src = 1'b1;
        dec_imm = imm_s(instr_i);
        dec_alu = ALU_ADDR;
      end
      OPC_BRANCH: begin
        dec_br  = 1'b1;
        dec_imm = imm_b(instr_i);
        case (funct3)
          3'b000:  dec_alu = 5'b10010;
          3'b001:  dec_alu = 5'b10011;
          3'b100:  dec_alu = 5'b10100;
          3'b101:  dec_alu = 5'b10101;
          3'b110:  dec_alu = 5'b10110;
          3'b111:  dec_alu = 5'b10111;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_JAL: begin
        wr_rd   = 1'b1;
        dec_jp  = 1'b1;
        dec_imm = imm_j(instr_i);
        dec_alu = ALU_JAL;
      end
      OPC_JALR: begin
        wr_rd   = 1'b1;
        dec_jp  = 1'b1;
        dec_src = 1'b1;
        dec_imm = imm_i(instr_i);
        dec_alu = ALU_JALR;
      end
      OPC_LUI: begin
        wr_rd   = 1'b1;
        dec_src = 1'b1;
        dec_imm = imm_u(instr_i);
        dec_alu = ALU_LUI;
      end
      OPC_AUIPC: begin
        wr_rd   = 1'b1;
        dec_src = 1'b1;
        dec_imm = imm_u(instr_i);
        dec_alu = ALU_AUIPC;
      end
      default: dec_ill = 1'b1;
    endcase
    // An illegal encoding must not leave any side-effecting flag behind.
    if (dec_ill) begin
      dec_alu = ALU_ILL;
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_br  = 1'b0;
      dec_jp  = 1'b0;
    end
    dec_rw = wr_rd && (rd_idx != 5'd0) && !dec_ill;
  end

  logic            vld_p0;
  logic [4:0]      aluctrl_p0;
  logic            alusrc_p0;
  logic [XLEN-1:0] imm_p0, pc_p0;
  logic [4:0]      rs1_p0, rs2_p0, rd_p0;
  logic            rw_p0, mr_p0, mw_p0, br_p0, jp_p0, ill_p0;
  logic            xfer;

  assign in_ready_o = !vld_p0 || out_ready_i;
  assign xfer       = in_valid_i && in_ready_o;

  // Stage p0: output register, loaded only on an accepted, unflushed transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0     <= 1'b0;
      aluctrl_p0 <= ALU_ILL;
      alusrc_p0  <= 1'b0;
      imm_p0     <= '0;
      pc_p0      <= '0;
      rs1_p0     <= '0;
      rs2_p0     <= '0;
      rd_p0      <= '0;
      rw_p0      <= 1'b0;
      mr_p0      <= 1'b0;
      mw_p0      <= 1'b0;
      br_p0      <= 1'b0;
      jp_p0      <= 1'b0;
      ill_p0     <= 1'b0;
    end else if (flush_i) begin
      vld_p0 <= 1'b0;
    end else if (xfer) begin
      vld_p0     <= 1'b1;
      aluctrl_p0 <= dec_alu;
      alusrc_p0  <= dec_src;
      imm_p0     <= dec_imm;
      pc_p0      <= pc_i;
      rs1_p0     <= instr_i[19:15];
      rs2_p0     <= instr_i[24:20];
      rd_p0      <= rd_idx;
      rw_p0      <= dec_rw;
      mr_p0      <= dec_mr;
      mw_p0      <= dec_mw;
      br_p0      <= dec_br;
      jp_p0      <= dec_jp;
      ill_p0     <= dec_ill;
    end else if (out_ready_i) begin
      vld_p0 <= 1'b0;
    end
  end

  assign out_valid_o = vld_p0;
  assign aluctrl_o   = aluctrl_p0;
  assign alusrc_o    = alusrc_p0;
  assign imm_o       = imm_p0;
  assign pc_o        = pc_p0;
  assign rs1_o       = rs1_p0;
  assign rs2_o       = rs2_p0;
  assign rd_o        = rd_p0;
  assign regwrite_o  = rw_p0;
  assign memread_o   = mr_p0;
  assign memwrite_o  = mw_p0;
  assign branch_o    = br_p0;
  assign jump_o      = jp_p0;
  assign illegal_o   = ill_p0;

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Bench for alu_ctrl_decode: directed plan cases plus randomized handshake traffic
// checked against a behavioural decode/handshake model.
module tb_alu_ctrl_decode;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, in_valid_i, out_ready_i;
  logic        in_ready_o, out_valid_o;
  logic [31:0] instr_i, pc_i, imm_o, pc_o;
  logic [4:0]  aluctrl_o, rs1_o, rs2_o, rd_o;
  logic        alusrc_o, regwrite_o, memread_o, memwrite_o, branch_o, jump_o, illegal_o;

  always #5 clk_i = ~clk_i;

  alu_ctrl_decode #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .aluctrl_o(aluctrl_o), .alusrc_o(alusrc_o), .imm_o(imm_o), .pc_o(pc_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .regwrite_o(regwrite_o), .memread_o(memread_o), .memwrite_o(memwrite_o),
    .branch_o(branch_o), .jump_o(jump_o), .illegal_o(illegal_o)
  );

  typedef struct packed {
    logic [4:0]  alu;
    logic        src;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, br, jp, ill;
    logic        imm_care, src_care;
  } bundle_t;

  int      n_vec = 0;
  int      n_bad = 0;
  logic    m_vld;
  bundle_t m_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bundle_t rst_bundle();
    bundle_t b = '0;
    b.alu = 5'b11111;
    b.imm_care = 1'b1;
    b.src_care = 1'b1;
    return b;
  endfunction

  // Reference decoder built from the ISA field rules with integer arithmetic.
  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    bundle_t b = '0;
    int op, f3, f7, sgn, iI, iS, iB, iU, iJ;
    int base_code[8] = '{1, 2, 3, 4, 5, 7, 8, 9};
    bit writes = 0;
    op  = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    sgn = $signed(w) >>> 31;
    iI  = $signed(w) >>> 20;
    iS  = ((sgn * 128 + f7) * 32) + int'(w[11:7]);
    iB  = sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    iU  = int'(w & 32'hFFFFF000);
    iJ  = sgn * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    b.pc = pc;
    b.rs1 = w[19:15];
    b.rs2 = w[24:20];
    b.rd  = w[11:7];
    b.imm_care = 1'b1;
    b.src_care = 1'b1;
    case (op)
      'h33: begin
        writes = 1; b.imm_care = 0;
        if (f7 == 0) b.alu = 5'(base_code[f3]);
        else if (f7 == 32 && f3 == 0) b.alu = 5'd0;
        else if (f7 == 32 && f3 == 5) b.alu = 5'd6;
        else b.ill = 1;
      end
      'h13: begin
        writes = 1; b.src = 1;
        if (f3 == 1 || f3 == 5) begin
          b.imm = 32'(int'(w[24:20]));
          if (f7 == 0) b.alu = 5'(base_code[f3]);
          else if (f7 == 32 && f3 == 5) b.alu = 5'd6;
          else b.ill = 1;
        end else begin
          b.imm = 32'(iI);
          b.alu = 5'(base_code[f3]);
        end
      end
      'h03: begin writes = 1; b.mr = 1; b.src = 1; b.imm = 32'(iI); b.alu = 5'd10; end
      'h23: begin b.mw = 1; b.src = 1; b.imm = 32'(iS); b.alu = 5'd10; end
      'h63: begin
        b.imm = 32'(iB);
        if (f3 == 2 || f3 == 3) b.ill = 1;
        else begin
          b.br = 1;
          b.alu = 5'((f3 < 4) ? 18 + f3 : 16 + f3);
        end
      end
      'h6F: begin writes = 1; b.jp = 1; b.imm = 32'(iJ); b.alu = 5'd24; end
      'h67: begin writes = 1; b.jp = 1; b.src = 1; b.imm = 32'(iI); b.alu = 5'd25; end
      'h37: begin writes = 1; b.src = 1; b.imm = 32'(iU); b.alu = 5'd26; end
      'h17: begin writes = 1; b.src = 1; b.imm = 32'(iU); b.alu = 5'd27; end
      default: b.ill = 1;
    endcase
    if (b.ill) begin
      b.alu = 5'b11111;
      b.imm_care = 0;
      b.src_care = 0;
    end
    b.rw = writes && !b.ill && (w[11:7] != 0);
    return b;
  endfunction

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid_o), 32'(m_vld));
    chk("aluctrl",   32'(aluctrl_o),   32'(m_b.alu));
    if (m_b.src_care) chk("alusrc", 32'(alusrc_o), 32'(m_b.src));
    if (m_b.imm_care) chk("imm", imm_o, m_b.imm);
    chk("pc",        pc_o,             m_b.pc);
    chk("rs1",       32'(rs1_o),       32'(m_b.rs1));
    chk("rs2",       32'(rs2_o),       32'(m_b.rs2));
    chk("rd",        32'(rd_o),        32'(m_b.rd));
    chk("regwrite",  32'(regwrite_o),  32'(m_b.rw));
    chk("memread",   32'(memread_o),   32'(m_b.mr));
    chk("memwrite",  32'(memwrite_o),  32'(m_b.mw));
    chk("branch",    32'(branch_o),    32'(m_b.br));
    chk("jump",      32'(jump_o),      32'(m_b.jp));
    chk("illegal",   32'(illegal_o),   32'(m_b.ill));
  endtask

  // One clock: drive at the falling edge, check ready, advance model, check outputs.
  task automatic step(input logic v, input logic [31:0] ins, input logic rdy,
                      input logic fl, input logic rs);
    logic [31:0] pc;
    logic        xfer;
    pc = $urandom;
    in_valid_i = v; instr_i = ins; pc_i = pc;
    out_ready_i = rdy; flush_i = fl; rst_i = rs;
    #1;
    chk("in_ready", 32'(in_ready_o), 32'(!m_vld || rdy));
    xfer = v && (!m_vld || rdy);
    if (rs) begin
      m_vld = 1'b0;
      m_b = rst_bundle();
    end else if (fl) m_vld = 1'b0;
    else if (xfer) begin
      m_vld = 1'b1;
      m_b = ref_decode(ins, pc);
    end else if (rdy) m_vld = 1'b0;
    @(negedge clk_i);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  f7s[3];
    logic [6:0]  ops[10];
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 10) begin
      w[6:0] = (k == 9) ? 7'($urandom) : ops[k];
      f7s = '{7'h00, 7'h20, 7'($urandom)};
      if (k <= 1) w[31:25] = f7s[$urandom_range(0, 2)];
      if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    end
    return w;
  endfunction

  initial begin
    logic [31:0] held_alu;
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    instr_i = '0; pc_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    m_vld = 1'b0;
    m_b = rst_bundle();
    check_outputs();
    chk("reset_in_ready", 32'(in_ready_o), 32'd1);

    step(1, 32'h002081B3, 1, 0, 0);
    chk("tp_add_alu", 32'(aluctrl_o), 32'h01);
    chk("tp_add_rd",  32'(rd_o), 32'd3);
    step(1, 32'h402081B3, 1, 0, 0);
    chk("tp_sub_alu", 32'(aluctrl_o), 32'h00);
    step(1, 32'hFFF00293, 1, 0, 0);
    chk("tp_addi_imm", imm_o, 32'hFFFFFFFF);
    step(1, 32'h40435313, 1, 0, 0);
    chk("tp_srai_alu", 32'(aluctrl_o), 32'h06);
    chk("tp_srai_imm", imm_o, 32'h00000004);
    step(1, 32'h00208463, 1, 0, 0);
    chk("tp_beq_imm", imm_o, 32'h00000008);
    step(1, 32'h123450B7, 1, 0, 0);
    chk("tp_lui_imm", imm_o, 32'h12345000);

    // Stall with a new instruction waiting, then release.
    step(1, 32'h00A00093, 0, 0, 0);
    held_alu = 32'(aluctrl_o);
    for (int i = 0; i < 3; i++) step(1, 32'h002081B3, 0, 0, 0);
    chk("stall_in_ready", 32'(in_ready_o), 32'd0);
    chk("stall_hold", 32'(aluctrl_o), held_alu);
    step(1, 32'h002081B3, 1, 0, 0);
    chk("after_stall_alu", 32'(aluctrl_o), 32'h01);

    step(1, 32'h402081B3, 1, 1, 0);
    chk("flush_valid", 32'(out_valid_o), 32'd0);
    step(1, 32'h002081B3, 0, 0, 0);
    step(1, 32'h402081B3, 0, 0, 1);
    chk("rst_stall_alu", 32'(aluctrl_o), 32'h1F);
    step(1, 32'hFFFFFFFF, 1, 0, 0);
    chk("illegal_valid", 32'(out_valid_o), 32'd1);
    chk("illegal_flag", 32'(illegal_o), 32'd1);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
